// File: rtl/mem_responder.sv
// Two-port read responder: instruction and data requests are queued in separate
// FIFOs and served one at a time from a single backing memory, data first.
module mem_responder #(
  parameter int QDEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        INST_RDEN,
  input  logic [31:0] INST_RADDR,
  output logic        INST_RVALID,
  output logic [31:0] INST_RDATA,
  input  logic        DATA_RDEN,
  input  logic [31:0] DATA_RADDR,
  output logic        DATA_RVALID,
  output logic [31:0] DATA_RDATA,
  output logic        MEM_WAIT,
  output logic        MEM_REQ,
  output logic [31:0] MEM_ADDR,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  logic [31:0]   inst_q [QDEPTH];
  logic [31:0]   data_q [QDEPTH];
  logic [PW-1:0] inst_wr, inst_rd, data_wr, data_rd;
  logic [CW-1:0] inst_cnt, data_cnt;
  state_t        state;
  logic          src_data;
  logic          inst_push, data_push, inst_pop, data_pop;

  // Either full FIFO stalls both ports, so a same-cycle pair is never split.
  assign MEM_WAIT  = RST || (inst_cnt == CW'(QDEPTH)) || (data_cnt == CW'(QDEPTH));
  assign inst_push = INST_RDEN && !MEM_WAIT;
  assign data_push = DATA_RDEN && !MEM_WAIT;
  assign data_pop  = (state == IDLE) && (data_cnt != '0);
  assign inst_pop  = (state == IDLE) && (data_cnt == '0) && (inst_cnt != '0);

  always_ff @(posedge CLK) begin
    if (inst_push) inst_q[inst_wr] <= INST_RADDR;
    if (data_push) data_q[data_wr] <= DATA_RADDR;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      inst_wr  <= '0;
      inst_rd  <= '0;
      inst_cnt <= '0;
      data_wr  <= '0;
      data_rd  <= '0;
      data_cnt <= '0;
    end else begin
      if (inst_push) inst_wr <= inst_wr + 1'b1;
      if (inst_pop)  inst_rd <= inst_rd + 1'b1;
      if (data_push) data_wr <= data_wr + 1'b1;
      if (data_pop)  data_rd <= data_rd + 1'b1;
      case ({inst_push, inst_pop})
        2'b10:   inst_cnt <= inst_cnt + 1'b1;
        2'b01:   inst_cnt <= inst_cnt - 1'b1;
        default: inst_cnt <= inst_cnt;
      endcase
      case ({data_push, data_pop})
        2'b10:   data_cnt <= data_cnt + 1'b1;
        2'b01:   data_cnt <= data_cnt - 1'b1;
        default: data_cnt <= data_cnt;
      endcase
    end
  end

  // Access sequencer; RVALIDs are single-cycle pulses, RDATA holds between them.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      MEM_REQ     <= 1'b0;
      MEM_ADDR    <= '0;
      src_data    <= 1'b0;
      INST_RVALID <= 1'b0;
      DATA_RVALID <= 1'b0;
      INST_RDATA  <= '0;
      DATA_RDATA  <= '0;
    end else begin
      INST_RVALID <= 1'b0;
      DATA_RVALID <= 1'b0;
      case (state)
        IDLE: begin
          if (data_pop) begin
            MEM_REQ  <= 1'b1;
            MEM_ADDR <= data_q[data_rd] & ~32'h3;
            src_data <= 1'b1;
            state    <= BUSY;
          end else if (inst_pop) begin
            MEM_REQ  <= 1'b1;
            MEM_ADDR <= inst_q[inst_rd] & ~32'h3;
            src_data <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (MEM_ACK) begin
            MEM_REQ <= 1'b0;
            state   <= IDLE;
            if (src_data) begin
              DATA_RVALID <= 1'b1;
              DATA_RDATA  <= MEM_RDATA;
            end else begin
              INST_RVALID <= 1'b1;
              INST_RDATA  <= MEM_RDATA;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
